fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory, decode-side and redirect signals for fetch_unit.
// The master view belongs to the fetch unit; the slave view belongs to its environment.
interface fetch_unit_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr_set;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic        br_taken;
    logic [15:0] br_target;
    logic        fault;

    modport master (
        output imem_rd, imem_addr, instr_set, instr_valid, instr_pc, fault,
        input  imem_rdata, imem_valid, instr_ready, br_taken, br_target
    );

    modport slave (
        input  imem_rd, imem_addr, instr_set, instr_valid, instr_pc, fault,
        output imem_rdata, imem_valid, instr_ready, br_taken, br_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with branch redirect,
// stale-response discard and a sticky memory-timeout fault.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

    logic [1:0]  r_state;
    logic [15:0] r_fetch_pc;
    logic [15:0] r_instr_set;
    logic [15:0] r_instr_pc;
    logic [15:0] r_tmo;
    logic        r_instr_valid;
    logic        r_fault;
    logic        r_discard;

    logic [15:0] w_tmo_inc;
    logic        w_tmo_hit;
    logic        w_imem_rd;

    assign w_tmo_inc = r_tmo + 16'd1;
    assign w_tmo_hit = (w_tmo_inc == TMO_LIMIT);

    // A redirect in S_REQ retargets the PC instead of issuing, so a request
    // for the abandoned address never goes out; reset also masks the pulse.
    assign w_imem_rd = reset && (r_state == S_REQ) && !bus.br_taken;

    assign bus.imem_rd     = w_imem_rd;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_set   = r_instr_set;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.fault       = r_fault;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_REQ;
            r_fetch_pc    <= RESET_PC;
            r_instr_set   <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_discard     <= 1'b0;
            r_tmo         <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.br_taken) begin
                        r_fetch_pc <= bus.br_target;
                    end else begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.br_taken) begin
                        r_fetch_pc <= bus.br_target;
                    end
                    // A response that coincides with a redirect is already the
                    // stale word, so it is dropped without waiting any further.
                    if (bus.imem_valid) begin
                        if (bus.br_taken || r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_instr_set   <= bus.imem_rdata;
                            r_instr_pc    <= r_fetch_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_FULL;
                        end
                    end else begin
                        if (bus.br_taken) begin
                            r_discard <= 1'b1;
                        end
                        r_tmo <= w_tmo_inc;
                        if (w_tmo_hit) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end
                    end
                end

                S_FULL: begin
                    if (bus.br_taken) begin
                        r_fetch_pc    <= bus.br_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end else if (r_instr_valid && bus.instr_ready) begin
                        r_fetch_pc    <= r_fetch_pc + 16'd1;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end

                S_FAULT: begin
                    r_instr_valid <= 1'b0;
                end

                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory with adjustable latency
// and hand-timed cycle-by-cycle expectations.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC    (16'h0000),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          lat     = 1;
    bit          mem_on  = 1'b1;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responses are driven just after the edge; requests are captured mid-cycle.
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = mem_word(mem_addr);
                end
            end
            @(negedge clk);
            if (bus.imem_rd && mem_on) begin
                mem_cnt  = lat;
                mem_addr = bus.imem_addr;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset           = 1'b0;
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = '0;

        repeat (3) begin
            next(); #1;
            check("rst_rd", 16'(bus.imem_rd), 16'h0);
        end
        check("rst_valid", 16'(bus.instr_valid), 16'h0);
        check("rst_fault", 16'(bus.fault), 16'h0);
        check("rst_set", bus.instr_set, 16'h0000);
        check("rst_pc", bus.instr_pc, 16'h0000);

        // Back-to-back fetch, latency 1, decode always ready: 3 cycles each
        next(); reset = 1'b1; bus.instr_ready = 1'b1; #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                next(); #1;
            end
            check("seq_rd", 16'(bus.imem_rd), 16'((i % 3) == 0));
            if ((i % 3) == 0) check("seq_addr", bus.imem_addr, 16'(i / 3));
            check("seq_valid", 16'(bus.instr_valid), 16'((i % 3) == 2));
            if ((i % 3) == 2) begin
                check("seq_set", bus.instr_set, mem_word(16'(i / 3)));
                check("seq_pc", bus.instr_pc, 16'(i / 3));
            end
        end

        // Decode stall in S_FULL
        next(); bus.instr_ready = 1'b0; #1;
        check("stall_req_addr", bus.imem_addr, 16'h0003);
        next(); #1;
        for (int k = 0; k < 5; k++) begin
            next(); #1;
            check("stall_valid", 16'(bus.instr_valid), 16'h1);
            check("stall_set", bus.instr_set, mem_word(16'h0003));
            check("stall_pc", bus.instr_pc, 16'h0003);
            check("stall_rd", 16'(bus.imem_rd), 16'h0);
        end
        next(); bus.instr_ready = 1'b1; #1;

        // Redirect while waiting on a 3-cycle memory
        next(); lat = 3; #1;
        check("wbr_rd", 16'(bus.imem_rd), 16'h1);
        check("wbr_addr", bus.imem_addr, 16'h0004);
        next(); bus.br_taken = 1'b1; bus.br_target = 16'h0040; #1;
        check("wbr_wait_rd", 16'(bus.imem_rd), 16'h0);
        next(); bus.br_taken = 1'b0; #1;
        check("wbr_wait_valid", 16'(bus.instr_valid), 16'h0);
        next(); #1;
        check("wbr_stale_valid", 16'(bus.instr_valid), 16'h0);
        check("wbr_stale_rd", 16'(bus.imem_rd), 16'h0);
        next(); lat = 1; #1;
        check("wbr_new_rd", 16'(bus.imem_rd), 16'h1);
        check("wbr_new_addr", bus.imem_addr, 16'h0040);
        next(); #1;

        // Redirect and handshake in the same S_FULL cycle
        next(); bus.br_taken = 1'b1; bus.br_target = 16'h0100; #1;
        check("fbr_valid", 16'(bus.instr_valid), 16'h1);
        check("fbr_set", bus.instr_set, mem_word(16'h0040));
        check("fbr_pc", bus.instr_pc, 16'h0040);
        next(); bus.br_taken = 1'b0; #1;
        check("fbr_drop", 16'(bus.instr_valid), 16'h0);
        check("fbr_rd", 16'(bus.imem_rd), 16'h1);
        check("fbr_addr", bus.imem_addr, 16'h0100);
        next(); #1;
        next(); #1;
        check("fbr_new_pc", bus.instr_pc, 16'h0100);

        // PC wrap from 16'hFFFF
        next(); bus.br_taken = 1'b1; bus.br_target = 16'hFFFF; #1;
        next(); bus.br_taken = 1'b0; #1;
        check("wrap_rd", 16'(bus.imem_rd), 16'h1);
        check("wrap_top_addr", bus.imem_addr, 16'hFFFF);
        next(); #1;
        next(); #1;
        check("wrap_set", bus.instr_set, mem_word(16'hFFFF));
        check("wrap_pc", bus.instr_pc, 16'hFFFF);
        next(); lat = 2; #1;
        check("wrap_addr", bus.imem_addr, 16'h0000);
        check("wrap_next_rd", 16'(bus.imem_rd), 16'h1);

        // Reset mid-transaction; the late response lands in the first S_REQ cycle
        next(); reset = 1'b0; #1;
        check("mid_rst_rd", 16'(bus.imem_rd), 16'h0);
        next(); reset = 1'b1; lat = 1; #1;
        check("mid_rd", 16'(bus.imem_rd), 16'h1);
        check("mid_addr", bus.imem_addr, 16'h0000);
        check("mid_set", bus.instr_set, 16'h0000);
        check("mid_pc", bus.instr_pc, 16'h0000);
        next(); #1;
        check("mid_late_ignored", 16'(bus.instr_valid), 16'h0);
        next(); #1;
        check("mid_valid", 16'(bus.instr_valid), 16'h1);
        check("mid_new_set", bus.instr_set, mem_word(16'h0000));

        // Memory never answers: fault after 15 cycles in S_WAIT
        next(); mem_on = 1'b0; #1;
        check("tmo_rd", 16'(bus.imem_rd), 16'h1);
        check("tmo_addr", bus.imem_addr, 16'h0001);
        for (int k = 0; k < 15; k++) begin
            next(); #1;
            check("tmo_nofault", 16'(bus.fault), 16'h0);
        end
        next(); #1;
        check("tmo_fault", 16'(bus.fault), 16'h1);
        check("tmo_fault_rd", 16'(bus.imem_rd), 16'h0);
        check("tmo_fault_valid", 16'(bus.instr_valid), 16'h0);
        for (int k = 0; k < 3; k++) begin
            next(); bus.br_taken = 1'b1; bus.br_target = 16'h0200; mem_on = 1'b1; #1;
            check("tmo_sticky", 16'(bus.fault), 16'h1);
            check("tmo_sticky_rd", 16'(bus.imem_rd), 16'h0);
        end
        next(); bus.br_taken = 1'b0; reset = 1'b0; #1;
        check("tmo_rst_rd", 16'(bus.imem_rd), 16'h0);
        next(); reset = 1'b1; #1;
        check("tmo_clear", 16'(bus.fault), 16'h0);
        check("tmo_restart_rd", 16'(bus.imem_rd), 16'h1);
        check("tmo_restart_addr", bus.imem_addr, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
